pin_entry_ctrl: RTL and testbench
=================================

# pin_entry_ctrl

Keypad PIN-entry controller for the door-lock/LCD design. It consumes decoded key events (digits 0-9, `#` = enter, `*` = clear) from the PS/2 key-decoder path and collects a fixed-length PIN. It compares the PIN against a stored code, then sequences the unlock, error, lockout and PIN-reprogramming phases with cycle-accurate timers. It also drives the LED/lock outputs and echo strobes for the LCD writer.

## Interface
- PIN_LEN, 4: digits per PIN (1-8); stored PIN is 4*PIN_LEN bits, BCD, digit 0 is the most significant nibble.
- DEFAULT_PIN, 16'h1234: PIN loaded at reset.
- TIMEOUT_CYC, 150000000: inactivity limit (3 s at 50 MHz) in the ENTRY and PROG states.
- UNLOCK_CYC, 150000000: cycles oUNLOCK is held.
- ERR_CYC, 50000000: cycles oERR is held after a wrong PIN.
- LOCK_CYC, 500000000: lockout duration.
- MAX_FAIL, 3: consecutive failures that trigger lockout (1-15).
- iCLK_50  in  1  system clock, 50 MHz.
- iRST  in  1  reset, asynchronous, active-high.
- iKEY_VALID  in  1  one-cycle key strobe.
- iKEY_CODE  in  4  0-9 digit, 0xA `#`, 0xB `*`, 0xC-0xF invalid.
- oUNLOCK  out  1  lock release (level).
- oERR  out  1  wrong-PIN indication (level).
- oALARM  out  1  lockout active (level).
- oPROG_DONE  out  1  one-cycle pulse when a new PIN is stored.
- oDIGIT_CNT  out  4  digits currently buffered.
- oECHO_VALID  out  1  one-cycle pulse per accepted digit.
- oECHO_CHAR  out  8  ASCII echo: 8'h2A (`*`) in ENTRY; the digit's ASCII code (8'h30+d) in PROG.
- oECHO_CLR  out  1  one-cycle pulse when the buffer is cleared by `*` or by timeout.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, PROG, FAIL, LOCKOUT. Reset state is IDLE.
- Reset values: all outputs 0, buffer 0, count 0, fail counter 0, timer 0, stored PIN = DEFAULT_PIN. Reset mid-operation aborts immediately, including PROG; a partially entered new PIN is discarded.
- Invalid codes (0xC-0xF) are ignored in every state and do not restart the timer.
- IDLE: a digit shifts into the buffer, sets count=1, pulses echo and moves to ENTRY. `#` and `*` are ignored.
- ENTRY:
  - digit with count<PIN_LEN: shift in, count+1, echo. Digit with count==PIN_LEN: ignored, no echo, timer still restarts.
  - `*`: clear buffer, count=0, oECHO_CLR, go to IDLE.
  - `#`: go to CHECK.
  - timer reaching TIMEOUT_CYC: clear buffer, oECHO_CLR, go to IDLE.
- CHECK (one cycle): match means count==PIN_LEN and buffer==stored PIN.
  - match: fail counter=0, go to OPEN.
  - mismatch: fail counter+1. If the new value equals MAX_FAIL, go to LOCKOUT; otherwise go to FAIL.
  - The buffer and count clear on leaving CHECK.
- OPEN:
  - oUNLOCK=1. After UNLOCK_CYC cycles, go to IDLE.
  - `*`: go to PROG; oUNLOCK drops and the buffer is empty.
  - Digits and `#` are ignored.
- PROG:
  - digits: same buffering and timeout rules as ENTRY, with ASCII echo.
  - `#` with count==PIN_LEN: stored PIN <= buffer, pulse oPROG_DONE, go to IDLE.
  - `#` with a short count: go to IDLE, PIN unchanged.
  - `*`: clear buffer, stay in PROG.
  - timeout: go to IDLE, PIN unchanged.
- FAIL: oERR=1 for ERR_CYC cycles, then go to IDLE. All keys are ignored.
- LOCKOUT: oALARM=1 for LOCK_CYC cycles, then fail counter=0 and go to IDLE. All keys are ignored.
- Timer: 32-bit. It clears on every state entry and on every accepted digit, `*` or `#`.

## Timing
- All outputs are registered. Key strobe sampled at edge N: the state, buffer, oDIGIT_CNT and echo pulses update at edge N.
- `#` sampled at edge N: CHECK occupies N..N+1; oUNLOCK, oERR or oALARM rises at edge N+1.
- Level outputs stay high exactly UNLOCK_CYC, ERR_CYC or LOCK_CYC cycles.
- Timeout fires at the edge where the timer would reach TIMEOUT_CYC, i.e. TIMEOUT_CYC cycles after the last accepted key.
- A key strobe in the same cycle as timeout expiry: the key wins; it is processed and the timer restarts.
- Back-to-back strobes on consecutive cycles must all be processed.

## Test plan
Bench parameters: PIN_LEN=4, DEFAULT_PIN=16'h1234, TIMEOUT_CYC=20, UNLOCK_CYC=8, ERR_CYC=4, LOCK_CYC=16, MAX_FAIL=3.

- Keys 1,2,3,4,`#` -> 4 echo pulses with char 8'h2A; oDIGIT_CNT 1..4; oUNLOCK high 8 cycles from 1 cycle after the `#` edge; oERR and oALARM stay 0.
- Keys 1,2,3,5,`#` -> oERR high 4 cycles, return to IDLE. Repeat 3 times -> third attempt gives oALARM high 16 cycles with no oERR. Keys during lockout are ignored. Afterwards 1,2,3,4,`#` unlocks.
- Keys 1,2 then 20 idle cycles -> oECHO_CLR pulse, oDIGIT_CNT=0. Keys 1,2,`*`,1,2,3,4,`#` -> unlock.
- Keys 1,2,3,4,5,`#` -> fifth digit produces no echo; unlock succeeds. Keys 1,2,3,`#` -> error.
- Unlock, then `*`,9,8,7,6,`#` -> echo chars 8'h39,8'h38,8'h37,8'h36; oPROG_DONE pulse. 1,2,3,4,`#` then errors; 9,8,7,6,`#` unlocks. Assert iRST -> PIN reverts to 16'h1234.
- Strobe at the exact timeout cycle and iRST asserted mid-ENTRY -> the key is accepted; on reset, all outputs go to 0 asynchronously and the state returns to IDLE.

Source files
------------

// File: rtl/pin_entry_ctrl_if.sv
// Key-event input and lock/echo output bundle for the PIN-entry controller.
// The key source drives the master side; the controller is the slave.
interface pin_entry_ctrl_if;
  logic       iKEY_VALID;
  logic [3:0] iKEY_CODE;
  logic       oUNLOCK;
  logic       oERR;
  logic       oALARM;
  logic       oPROG_DONE;
  logic [3:0] oDIGIT_CNT;
  logic       oECHO_VALID;
  logic [7:0] oECHO_CHAR;
  logic       oECHO_CLR;

  modport master (
    output iKEY_VALID, iKEY_CODE,
    input  oUNLOCK, oERR, oALARM, oPROG_DONE, oDIGIT_CNT,
           oECHO_VALID, oECHO_CHAR, oECHO_CLR
  );

  modport slave (
    input  iKEY_VALID, iKEY_CODE,
    output oUNLOCK, oERR, oALARM, oPROG_DONE, oDIGIT_CNT,
           oECHO_VALID, oECHO_CHAR, oECHO_CLR
  );
endinterface

// File: rtl/pin_entry_ctrl.sv
// Keypad PIN-entry controller: collects digits, checks against the stored PIN and
// sequences unlock, error, lockout and PIN reprogramming with cycle timers.
//   state   | meaning
//   IDLE    | waiting for the first digit
//   ENTRY   | collecting digits of a PIN attempt
//   CHECK   | one-cycle compare against the stored PIN
//   OPEN    | lock released; '*' enters reprogramming
//   PROG    | collecting a new PIN
//   FAIL    | wrong-PIN indication
//   LOCKOUT | too many failures, keys ignored
module pin_entry_ctrl #(
  parameter int                     PIN_LEN     = 4,
  parameter logic [4*PIN_LEN-1:0]   DEFAULT_PIN = 16'h1234,
  parameter int unsigned            TIMEOUT_CYC = 150000000,
  parameter int unsigned            UNLOCK_CYC  = 150000000,
  parameter int unsigned            ERR_CYC     = 50000000,
  parameter int unsigned            LOCK_CYC    = 500000000,
  parameter int                     MAX_FAIL    = 3
) (
  input  logic          iCLK_50,
  input  logic          iRST,
  pin_entry_ctrl_if.slave bus
);

  localparam int          BUF_W       = 4 * PIN_LEN;
  localparam logic [3:0]  LEN         = 4'(PIN_LEN);
  localparam logic [3:0]  FAIL_MAX    = 4'(MAX_FAIL);
  localparam logic [31:0] TMO_LAST    = TIMEOUT_CYC - 1;
  localparam logic [31:0] UNLOCK_LAST = UNLOCK_CYC - 1;
  localparam logic [31:0] ERR_LAST    = ERR_CYC - 1;
  localparam logic [31:0] LOCK_LAST   = LOCK_CYC - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_PROG, S_FAIL, S_LOCKOUT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [BUF_W-1:0]   r_buf, w_buf_nxt, r_pin, w_pin_nxt, w_buf_shift;
  logic [3:0]         r_cnt, w_cnt_nxt, r_fail, w_fail_nxt, w_fail_inc;
  logic [31:0]        r_timer, w_timer_nxt;
  logic               r_unlock, r_err, r_alarm, r_prog_done, r_echo_valid, r_echo_clr;
  logic [7:0]         r_echo_char, w_echo_char;
  logic               w_prog_done, w_echo_valid, w_echo_clr;
  logic [3:0]         w_code;
  logic               w_is_digit, w_is_enter, w_is_clr, w_tmo, w_match;

  assign w_code      = bus.iKEY_CODE;
  assign w_is_digit  = bus.iKEY_VALID && (w_code <= 4'd9);
  assign w_is_enter  = bus.iKEY_VALID && (w_code == 4'hA);
  assign w_is_clr    = bus.iKEY_VALID && (w_code == 4'hB);
  assign w_tmo       = (r_timer == TMO_LAST);
  assign w_buf_shift = (r_buf << 4) | BUF_W'(w_code);
  assign w_match     = (r_cnt == LEN) && (r_buf == r_pin);
  assign w_fail_inc  = r_fail + 4'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_fail_nxt   = r_fail;
    w_pin_nxt    = r_pin;
    w_timer_nxt  = r_timer + 32'd1;
    w_echo_valid = 1'b0;
    w_echo_char  = 8'h00;
    w_echo_clr   = 1'b0;
    w_prog_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_is_digit) begin
          w_buf_nxt    = BUF_W'(w_code);
          w_cnt_nxt    = 4'd1;
          w_echo_valid = 1'b1;
          w_echo_char  = 8'h2A;
          w_state_nxt  = S_ENTRY;
        end
      end
      S_ENTRY, S_PROG: begin
        // A key arriving on the expiry cycle wins over the timeout.
        if (w_is_digit) begin
          w_timer_nxt = '0;
          if (r_cnt < LEN) begin
            w_buf_nxt    = w_buf_shift;
            w_cnt_nxt    = r_cnt + 4'd1;
            w_echo_valid = 1'b1;
            w_echo_char  = (r_state == S_PROG) ? (8'h30 + {4'h0, w_code}) : 8'h2A;
          end
        end else if (w_is_clr) begin
          w_timer_nxt = '0;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_echo_clr  = 1'b1;
          if (r_state == S_ENTRY) w_state_nxt = S_IDLE;
        end else if (w_is_enter) begin
          w_timer_nxt = '0;
          if (r_state == S_ENTRY) begin
            w_state_nxt = S_CHECK;
          end else begin
            if (r_cnt == LEN) begin
              w_pin_nxt   = r_buf;
              w_prog_done = 1'b1;
            end
            w_buf_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end else if (w_tmo) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_echo_clr  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        w_buf_nxt = '0;
        w_cnt_nxt = '0;
        if (w_match) begin
          w_fail_nxt  = '0;
          w_state_nxt = S_OPEN;
        end else begin
          w_fail_nxt  = w_fail_inc;
          w_state_nxt = (w_fail_inc == FAIL_MAX) ? S_LOCKOUT : S_FAIL;
        end
      end
      S_OPEN: begin
        if (w_is_clr) w_state_nxt = S_PROG;
        else if (r_timer == UNLOCK_LAST) w_state_nxt = S_IDLE;
      end
      S_FAIL: begin
        if (r_timer == ERR_LAST) w_state_nxt = S_IDLE;
      end
      S_LOCKOUT: begin
        if (r_timer == LOCK_LAST) begin
          w_fail_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt != r_state) w_timer_nxt = '0;
  end

  // Level outputs are registered decodes of the next state so they rise with it.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_fail       <= '0;
      r_timer      <= '0;
      r_pin        <= DEFAULT_PIN;
      r_unlock     <= 1'b0;
      r_err        <= 1'b0;
      r_alarm      <= 1'b0;
      r_prog_done  <= 1'b0;
      r_echo_valid <= 1'b0;
      r_echo_char  <= 8'h00;
      r_echo_clr   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_buf        <= w_buf_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fail       <= w_fail_nxt;
      r_timer      <= w_timer_nxt;
      r_pin        <= w_pin_nxt;
      r_unlock     <= (w_state_nxt == S_OPEN);
      r_err        <= (w_state_nxt == S_FAIL);
      r_alarm      <= (w_state_nxt == S_LOCKOUT);
      r_prog_done  <= w_prog_done;
      r_echo_valid <= w_echo_valid;
      r_echo_char  <= w_echo_char;
      r_echo_clr   <= w_echo_clr;
    end
  end

  assign bus.oUNLOCK     = r_unlock;
  assign bus.oERR        = r_err;
  assign bus.oALARM      = r_alarm;
  assign bus.oPROG_DONE  = r_prog_done;
  assign bus.oDIGIT_CNT  = r_cnt;
  assign bus.oECHO_VALID = r_echo_valid;
  assign bus.oECHO_CHAR  = r_echo_char;
  assign bus.oECHO_CLR   = r_echo_clr;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed bench for pin_entry_ctrl: unlock, error, lockout, timeout, reprogramming
// and asynchronous reset, with hand-computed expectations.
module tb_pin_entry_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pin_entry_ctrl_if bus ();

  pin_entry_ctrl #(
    .PIN_LEN(4), .DEFAULT_PIN(16'h1234), .TIMEOUT_CYC(20), .UNLOCK_CYC(8),
    .ERR_CYC(4), .LOCK_CYC(16), .MAX_FAIL(3)
  ) dut (
    .iCLK_50(clk),
    .iRST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic lvl(input int sel);
    case (sel)
      0:       return bus.oUNLOCK;
      1:       return bus.oERR;
      default: return bus.oALARM;
    endcase
  endfunction

  function automatic logic others(input int sel);
    case (sel)
      0:       return bus.oERR | bus.oALARM;
      1:       return bus.oUNLOCK | bus.oALARM;
      default: return bus.oUNLOCK | bus.oERR;
    endcase
  endfunction

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    bus.iKEY_VALID = 1'b1;
    bus.iKEY_CODE  = c;
    @(posedge clk);
    #1;
    bus.iKEY_VALID = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d, input logic exp_echo, input logic [7:0] exp_char,
                       input logic [3:0] exp_cnt);
    key(d);
    chk("echo_valid", bus.oECHO_VALID, exp_echo);
    if (exp_echo) chk("echo_char", bus.oECHO_CHAR, exp_char);
    chk("digit_cnt", bus.oDIGIT_CNT, exp_cnt);
  endtask

  task automatic entry4(input logic [15:0] pin);
    for (int i = 0; i < 4; i++) digit(pin[15-4*i -: 4], 1'b1, 8'h2A, 4'(i + 1));
  endtask

  // Counts the remaining high cycles of a level output, bounded so a stuck level still ends.
  task automatic finish_level(input string tag, input int sel, input int n0, input int exp_len);
    int   n;
    logic other;
    n = n0;
    other = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (lvl(sel)) begin
        n++;
        other = other | others(sel);
      end else break;
    end
    chk({tag, "_len"}, n, exp_len);
    chk({tag, "_other"}, other, 1'b0);
  endtask

  task automatic run_level(input string tag, input int sel, input int exp_len);
    @(posedge clk);
    #1;
    chk({tag, "_rise"}, lvl(sel), 1'b1);
    finish_level(tag, sel, 1, exp_len);
  endtask

  task automatic try_pin(input string tag, input logic [15:0] pin, input int sel, input int exp_len);
    entry4(pin);
    key(4'hA);
    chk({tag, "_check_quiet"}, {bus.oUNLOCK, bus.oERR, bus.oALARM}, 3'b000);
    run_level(tag, sel, exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.iKEY_VALID = 1'b0;
    bus.iKEY_CODE  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {bus.oUNLOCK, bus.oERR, bus.oALARM, bus.oPROG_DONE, bus.oECHO_VALID,
                        bus.oECHO_CLR}, 6'b0);
    chk("rst_cnt", bus.oDIGIT_CNT, 4'd0);
    chk("rst_char", bus.oECHO_CHAR, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // correct PIN
    entry4(16'h1234);
    key(4'hA);
    chk("enter_cnt", bus.oDIGIT_CNT, 4'd4);
    chk("enter_unlock", bus.oUNLOCK, 1'b0);
    run_level("unlock1", 0, 8);
    chk("open_cnt", bus.oDIGIT_CNT, 4'd0);

    // two wrong attempts, then lockout on the third
    try_pin("err1", 16'h1235, 1, 4);
    try_pin("err2", 16'h1235, 1, 4);
    entry4(16'h1235);
    key(4'hA);
    key(4'h1);
    chk("lock_rise", bus.oALARM, 1'b1);
    chk("lock_key1_echo", bus.oECHO_VALID, 1'b0);
    key(4'h2);
    key(4'hA);
    chk("lock_key_echo", bus.oECHO_VALID, 1'b0);
    chk("lock_key_cnt", bus.oDIGIT_CNT, 4'd0);
    chk("lock_still", bus.oALARM, 1'b1);
    finish_level("alarm", 2, 3, 16);
    try_pin("unlock_after_lock", 16'h1234, 0, 8);

    // extra digit ignored, short PIN errors
    entry4(16'h1234);
    digit(4'h5, 1'b0, 8'h00, 4'd4);
    key(4'hA);
    run_level("unlock_5th", 0, 8);
    digit(4'h1, 1'b1, 8'h2A, 4'd1);
    digit(4'h2, 1'b1, 8'h2A, 4'd2);
    digit(4'h3, 1'b1, 8'h2A, 4'd3);
    key(4'hA);
    run_level("err_short", 1, 4);

    // reprogramming from OPEN
    entry4(16'h1234);
    key(4'hA);
    @(posedge clk);
    #1;
    chk("prog_open_rise", bus.oUNLOCK, 1'b1);
    key(4'hB);
    chk("prog_unlock_drop", bus.oUNLOCK, 1'b0);
    chk("prog_cnt0", bus.oDIGIT_CNT, 4'd0);
    digit(4'h9, 1'b1, 8'h39, 4'd1);
    digit(4'h8, 1'b1, 8'h38, 4'd2);
    digit(4'h7, 1'b1, 8'h37, 4'd3);
    digit(4'h6, 1'b1, 8'h36, 4'd4);
    key(4'hA);
    chk("prog_done", bus.oPROG_DONE, 1'b1);
    @(posedge clk);
    #1;
    chk("prog_done_pulse", bus.oPROG_DONE, 1'b0);
    try_pin("old_pin_err", 16'h1234, 1, 4);
    entry4(16'h9876);
    key(4'hA);
    @(posedge clk);
    #1;
    chk("new_pin_unlock", bus.oUNLOCK, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_unlock", bus.oUNLOCK, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    try_pin("pin_reverted", 16'h1234, 0, 8);

    // inactivity timeout
    digit(4'h1, 1'b1, 8'h2A, 4'd1);
    digit(4'h2, 1'b1, 8'h2A, 4'd2);
    repeat (19) @(posedge clk);
    #1;
    chk("tmo_before", {bus.oECHO_CLR, bus.oDIGIT_CNT}, {1'b0, 4'd2});
    @(posedge clk);
    #1;
    chk("tmo_clr", bus.oECHO_CLR, 1'b1);
    chk("tmo_cnt", bus.oDIGIT_CNT, 4'd0);
    digit(4'h1, 1'b1, 8'h2A, 4'd1);
    digit(4'h2, 1'b1, 8'h2A, 4'd2);
    key(4'hB);
    chk("star_clr", bus.oECHO_CLR, 1'b1);
    chk("star_cnt", bus.oDIGIT_CNT, 4'd0);
    try_pin("unlock_after_star", 16'h1234, 0, 8);

    // key on the exact expiry cycle wins and restarts the timer
    digit(4'h1, 1'b1, 8'h2A, 4'd1);
    repeat (19) @(posedge clk);
    digit(4'h2, 1'b1, 8'h2A, 4'd2);
    chk("edge_key_noclr", bus.oECHO_CLR, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    chk("edge_restart", {bus.oECHO_CLR, bus.oDIGIT_CNT}, {1'b0, 4'd2});
    @(posedge clk);
    #1;
    chk("edge_tmo_clr", bus.oECHO_CLR, 1'b1);

    // async reset mid-ENTRY
    digit(4'h1, 1'b1, 8'h2A, 4'd1);
    digit(4'h2, 1'b1, 8'h2A, 4'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_cnt", bus.oDIGIT_CNT, 4'd0);
    chk("rst_mid_echo", bus.oECHO_VALID, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    try_pin("unlock_after_rst", 16'h1234, 0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
